// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default field widths, operand classes and
// width-generic constructors for the canonical special encodings.
package fp_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int DEF_GRS_W = 3;
    localparam int FP_MAX_W  = 64;

    typedef enum logic [2:0] {
        OP_ZERO   = 3'd0,
        OP_DENORM = 3'd1,
        OP_NORMAL = 3'd2,
        OP_INF    = 3'd3,
        OP_NAN    = 3'd4
    } op_class_e;

    // +INF: all-ones exponent, zero fraction, positive sign.
    function automatic logic [FP_MAX_W-1:0] fp_inf(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        return fp_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic op_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic frac_zero);
        if (exp_zero) return frac_zero ? OP_ZERO : OP_DENORM;
        if (exp_ones) return frac_zero ? OP_INF : OP_NAN;
        return OP_NORMAL;
    endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Combinational right shift of a mantissa that collapses every shifted-out bit
// into the result LSB (sticky), saturating to a pure sticky bit for large shifts.
module fp_align_shift #(
    parameter int MW    = 28,
    parameter int EXP_W = 8
) (
    input  logic [MW-1:0]    man_i,
    input  logic [EXP_W-1:0] shift_i,
    output logic [MW-1:0]    man_o
);

    logic [MW-1:0] lost_mask;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        lost_mask = ~({MW{1'b1}} << shift_i);
        if (32'(shift_i) >= 32'(MW - 1)) begin
            man_o = {{(MW-1){1'b0}}, |man_i};
        end else begin
            man_o = (man_i >> shift_i) | {{(MW-1){1'b0}}, |(man_i & lost_mask)};
        end
    end

endmodule

// File: rtl/fp_preadder_pipe.sv
// Two-stage FP pre-adder: stage 1 classifies, orders and resolves specials,
// stage 2 aligns the smaller mantissa; valid/ready handshake carries a tag.
module fp_preadder_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int GRS_W = DEF_GRS_W,
    parameter int TAG_W = 4,
    localparam int FP_W = 1 + EXP_W + MAN_W,
    localparam int MW   = MAN_W + GRS_W + 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  number_A,
    input  logic [FP_W-1:0]  number_B,
    input  logic             op_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_great,
    output logic             eff_sub,
    output logic [EXP_W-1:0] exp,
    output logic [MW-1:0]    mantis_great,
    output logic [MW-1:0]    mantis_small,
    output logic [FP_W-1:0]  special_result,
    output logic             special_case,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [FP_W-1:0]  QNAN    = FP_W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [FP_W-1:0]  INF     = FP_W'(fp_inf(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    typedef struct packed {
        logic             sign_great;
        logic             eff_sub;
        logic [EXP_W-1:0] exp_great;
        logic [MAN_W:0]   man_great;
        logic [MAN_W:0]   man_small;
        logic [EXP_W-1:0] shift;
        logic             special_case;
        logic [FP_W-1:0]  special_result;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             sign_great;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [MW-1:0]    mantis_great;
        logic [MW-1:0]    mantis_small;
        logic             special_case;
        logic [FP_W-1:0]  special_result;
        logic [TAG_W-1:0] tag;
    } s2_t;

    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b, eexp_a, eexp_b;
    logic [MAN_W-1:0] frac_a, frac_b;
    logic             hid_a, hid_b, a_great;
    op_class_e        cls_a, cls_b;

    logic s1_valid_q, s2_valid_q, s2_ready;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic [MW-1:0] man_small_ext, man_small_aligned;

    assign {sign_a, exp_a, frac_a} = number_A;
    assign sign_b          = number_B[FP_W-1] ^ op_sub;
    assign {exp_b, frac_b} = number_B[FP_W-2:0];

    assign cls_a  = fp_classify(exp_a == '0, &exp_a, frac_a == '0);
    assign cls_b  = fp_classify(exp_b == '0, &exp_b, frac_b == '0);
    assign hid_a  = (cls_a == OP_NORMAL);
    assign hid_b  = (cls_b == OP_NORMAL);
    assign eexp_a = (exp_a == '0) ? EXP_ONE : exp_a;
    assign eexp_b = (exp_b == '0) ? EXP_ONE : exp_b;
    // Raw fields order correctly even across the denormal/normal boundary.
    assign a_great = {exp_a, frac_a} >= {exp_b, frac_b};

    always_comb begin
        s1_d         = '0;
        s1_d.eff_sub = sign_a ^ sign_b;
        s1_d.tag     = in_tag;
        if (a_great) begin
            s1_d.sign_great = sign_a;
            s1_d.exp_great  = eexp_a;
            s1_d.man_great  = {hid_a, frac_a};
            s1_d.man_small  = {hid_b, frac_b};
            s1_d.shift      = eexp_a - eexp_b;
        end else begin
            s1_d.sign_great = sign_b;
            s1_d.exp_great  = eexp_b;
            s1_d.man_great  = {hid_b, frac_b};
            s1_d.man_small  = {hid_a, frac_a};
            s1_d.shift      = eexp_b - eexp_a;
        end
        s1_d.special_case = 1'b1;
        if (cls_a == OP_NAN || cls_b == OP_NAN) begin
            s1_d.special_result = QNAN;
        end else if (cls_a == OP_INF && cls_b == OP_INF && s1_d.eff_sub) begin
            s1_d.special_result = QNAN;
        end else if (cls_a == OP_INF) begin
            s1_d.special_result = INF | {sign_a, {(FP_W-1){1'b0}}};
        end else if (cls_b == OP_INF) begin
            s1_d.special_result = INF | {sign_b, {(FP_W-1){1'b0}}};
        end else if (cls_a == OP_ZERO && cls_b == OP_ZERO) begin
            s1_d.special_result = {sign_a & sign_b, {(FP_W-1){1'b0}}};
        end else begin
            s1_d.special_case = 1'b0;
        end
    end

    assign s2_ready = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;

    // NOTE: data registers are reset too, so every output reads 0 straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    assign man_small_ext = {1'b0, s1_q.man_small, {GRS_W{1'b0}}};

    fp_align_shift #(.MW(MW), .EXP_W(EXP_W)) u_align (
        .man_i   (man_small_ext),
        .shift_i (s1_q.shift),
        .man_o   (man_small_aligned)
    );

    always_comb begin
        s2_d                = '0;
        s2_d.sign_great     = s1_q.sign_great;
        s2_d.eff_sub        = s1_q.eff_sub;
        s2_d.exp            = s1_q.exp_great;
        s2_d.mantis_great   = {1'b0, s1_q.man_great, {GRS_W{1'b0}}};
        s2_d.mantis_small   = man_small_aligned;
        s2_d.special_case   = s1_q.special_case;
        s2_d.special_result = s1_q.special_result;
        s2_d.tag            = s1_q.tag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) s2_q <= s2_d;
        end
    end

    assign out_valid      = s2_valid_q;
    assign sign_great     = s2_q.sign_great;
    assign eff_sub        = s2_q.eff_sub;
    assign exp            = s2_q.exp;
    assign mantis_great   = s2_q.mantis_great;
    assign mantis_small   = s2_q.mantis_small;
    assign special_result = s2_q.special_result;
    assign special_case   = s2_q.special_case;
    assign out_tag        = s2_q.tag;

endmodule

// File: tb/tb_fp_preadder_pipe.sv
// Directed bench for fp_preadder_pipe at default widths: vector table plus
// backpressure and mid-flight reset sequences.
module tb_fp_preadder_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] number_A, number_B;
    logic        op_sub;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic        sign_great, eff_sub, special_case;
    logic [7:0]  exp;
    logic [27:0] mantis_great, mantis_small;
    logic [31:0] special_result;
    logic [3:0]  out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_preadder_pipe dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .number_A       (number_A),
        .number_B       (number_B),
        .op_sub         (op_sub),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .sign_great     (sign_great),
        .eff_sub        (eff_sub),
        .exp            (exp),
        .mantis_great   (mantis_great),
        .mantis_small   (mantis_small),
        .special_result (special_result),
        .special_case   (special_case),
        .out_tag        (out_tag)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        sc;
        logic [31:0] sr;
        logic [7:0]  ex;
        logic [27:0] mg;
        logic [27:0] ms;
        logic        sg;
        logic        es;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Backpressure/reset stimulus: 1.0 + 2^-k, so shift = k.
    task automatic drive_pair(input int k);
        number_A = 32'h3F80_0000;
        number_B = 32'h3F80_0000 - (32'(k) << 23);
        op_sub   = 1'b0;
        in_tag   = 4'(k);
    endtask

    task automatic fill_two();
        int accepted;
        logic fire;
        accepted  = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 10 && accepted < 2; cyc++) begin
            drive_pair(accepted);
            in_valid = 1'b1;
            #1;
            fire = in_ready;
            @(negedge clk);
            if (fire) accepted++;
        end
        check("fill.accepts", 64'(accepted), 64'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int sent, got, cycles;
        logic fire;
        logic [27:0] snap_ms;
        logic [7:0]  snap_exp;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h0, 8'h7F, 28'h4000000, 28'h4000000, 1'b0, 1'b0};
        vecs[1]  = '{32'h3F000000, 32'h3F800000, 1'b0, 1'b0, 32'h0, 8'h7F, 28'h4000000, 28'h2000000, 1'b0, 1'b0};
        vecs[2]  = '{32'h3F800000, 32'h30800000, 1'b0, 1'b0, 32'h0, 8'h7F, 28'h4000000, 28'h0000001, 1'b0, 1'b0};
        vecs[3]  = '{32'h3F800000, 32'h30800000, 1'b1, 1'b0, 32'h0, 8'h7F, 28'h4000000, 28'h0000001, 1'b0, 1'b1};
        vecs[4]  = '{32'h40400000, 32'h3F800000, 1'b1, 1'b0, 32'h0, 8'h80, 28'h6000000, 28'h2000000, 1'b0, 1'b1};
        vecs[5]  = '{32'hC0000000, 32'h3F800000, 1'b0, 1'b0, 32'h0, 8'h80, 28'h4000000, 28'h2000000, 1'b1, 1'b1};
        vecs[6]  = '{32'h41800000, 32'h3F800001, 1'b0, 1'b0, 32'h0, 8'h83, 28'h4000000, 28'h0400001, 1'b0, 1'b0};
        vecs[7]  = '{32'h00000001, 32'h00800000, 1'b0, 1'b0, 32'h0, 8'h01, 28'h4000000, 28'h0000008, 1'b0, 1'b0};
        vecs[8]  = '{32'h3F800000, 32'hBF800000, 1'b0, 1'b0, 32'h0, 8'h7F, 28'h4000000, 28'h4000000, 1'b0, 1'b1};
        vecs[9]  = '{32'h3F800000, 32'h33000001, 1'b0, 1'b0, 32'h0, 8'h7F, 28'h4000000, 28'h0000003, 1'b0, 1'b0};
        vecs[10] = '{32'h00000000, 32'h3F800000, 1'b0, 1'b0, 32'h0, 8'h7F, 28'h4000000, 28'h0000000, 1'b0, 1'b0};
        vecs[11] = '{32'h7F800000, 32'h7F800000, 1'b1, 1'b1, 32'h7FC00000, 8'h0, 28'h0, 28'h0, 1'b0, 1'b0};
        vecs[12] = '{32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h80000000, 8'h0, 28'h0, 28'h0, 1'b0, 1'b0};
        vecs[13] = '{32'h7FA00000, 32'h3F800000, 1'b0, 1'b1, 32'h7FC00000, 8'h0, 28'h0, 28'h0, 1'b0, 1'b0};
        vecs[14] = '{32'h7F800000, 32'h7F800000, 1'b0, 1'b1, 32'h7F800000, 8'h0, 28'h0, 28'h0, 1'b0, 1'b0};
        vecs[15] = '{32'h3F800000, 32'h7F800000, 1'b1, 1'b1, 32'hFF800000, 8'h0, 28'h0, 28'h0, 1'b0, 1'b0};
        vecs[16] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 8'h0, 28'h0, 28'h0, 1'b0, 1'b0};
        vecs[17] = '{32'hFFC00001, 32'h7F800000, 1'b1, 1'b1, 32'h7FC00000, 8'h0, 28'h0, 28'h0, 1'b0, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        number_A  = '0;
        number_B  = '0;
        op_sub    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.special_result", 64'(special_result), 64'd0);
        check("rst.mantis_great", 64'(mantis_great), 64'd0);
        check("rst.exp", 64'(exp), 64'd0);

        for (int i = 0; i < NV; i++) begin
            number_A  = vecs[i].a;
            number_B  = vecs[i].b;
            op_sub    = vecs[i].sub;
            in_tag    = 4'(i);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            check($sformatf("v%0d.in_ready", i), 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d.early_valid", i), 64'(out_valid), 64'd0);
            lat = 1;
            do begin
                @(negedge clk);
                lat++;
            end while (!out_valid && lat < 8);
            check($sformatf("v%0d.latency", i), 64'(lat), 64'd2);
            check($sformatf("v%0d.tag", i), 64'(out_tag), 64'(i % 16));
            check($sformatf("v%0d.special_case", i), 64'(special_case), 64'(vecs[i].sc));
            if (vecs[i].sc) begin
                check($sformatf("v%0d.special_result", i), 64'(special_result), 64'(vecs[i].sr));
            end else begin
                check($sformatf("v%0d.special_result", i), 64'(special_result), 64'd0);
                check($sformatf("v%0d.exp", i), 64'(exp), 64'(vecs[i].ex));
                check($sformatf("v%0d.mantis_great", i), 64'(mantis_great), 64'(vecs[i].mg));
                check($sformatf("v%0d.mantis_small", i), 64'(mantis_small), 64'(vecs[i].ms));
                check($sformatf("v%0d.sign_great", i), 64'(sign_great), 64'(vecs[i].sg));
                check($sformatf("v%0d.eff_sub", i), 64'(eff_sub), 64'(vecs[i].es));
            end
        end
        @(negedge clk);

        // Backpressure: two accepts fill the pipe, output held for 3 stalled cycles.
        fill_two();
        drive_pair(2);
        in_valid = 1'b1;
        #1;
        snap_ms  = mantis_small;
        snap_exp = exp;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("bp.stall%0d.in_ready", s), 64'(in_ready), 64'd0);
            check($sformatf("bp.stall%0d.out_valid", s), 64'(out_valid), 64'd1);
            check($sformatf("bp.stall%0d.tag", s), 64'(out_tag), 64'd0);
            check($sformatf("bp.stall%0d.ms_stable", s), 64'(mantis_small), 64'(snap_ms));
            check($sformatf("bp.stall%0d.exp_stable", s), 64'(exp), 64'(snap_exp));
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp.release.in_ready", 64'(in_ready), 64'd1);
        sent   = 2;
        got    = 0;
        cycles = 0;
        while (got < 5 && cycles < 20) begin
            if (sent < 5) begin
                drive_pair(sent);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            fire = in_valid && in_ready;
            if (out_valid) begin
                check($sformatf("bp.r%0d.tag", got), 64'(out_tag), 64'(got));
                check($sformatf("bp.r%0d.mantis_small", got), 64'(mantis_small), 64'(28'h4000000 >> got));
                check($sformatf("bp.r%0d.exp", got), 64'(exp), 64'h7F);
                got++;
            end
            if (fire) sent++;
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        check("bp.results", 64'(got), 64'd5);
        check("bp.cycles", 64'(cycles), 64'd5);

        // Reset with both stages holding data.
        fill_two();
        in_valid = 1'b0;
        check("rst2.pre_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst2.out_valid", 64'(out_valid), 64'd0);
        check("rst2.in_ready", 64'(in_ready), 64'd1);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rst2.stale%0d", c), 64'(out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_preadder_pipe.md
Name: fp_preadder_pipe

Overview:
Parametrised, pipelined successor to the combinational FP pre-adder stage. Unpacks two IEEE-754-style operands and applies an add/subtract mode bit. Classifies the operands, resolves special cases, orders them by magnitude, and aligns the smaller mantissa with guard/round/sticky bits. Sits between the operand source and the mantissa adder/normaliser, with a 2-stage valid/ready pipeline that carries a user tag.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width
GRS_W, 3, guard/round/sticky bits appended below the fraction (GRS_W >= 2)
TAG_W, 4, width of pass-through transaction tag
Derived: FP_W = 1+EXP_W+MAN_W; MW = MAN_W+GRS_W+2 (MW = 28 at defaults)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operand pair this cycle
number_A  in  FP_W  operand A
number_B  in  FP_W  operand B
op_sub  in  1  0 = A+B, 1 = A-B (inverts sign of B)
in_tag  in  TAG_W  user tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sign_great  out  1  sign of larger-magnitude operand (after op_sub)
eff_sub  out  1  effective subtraction (signs differ after op_sub)
exp  out  EXP_W  exponent of larger operand (denormal reported as 1)
mantis_great  out  MW  aligned mantissa of larger operand
mantis_small  out  MW  aligned and shifted mantissa of smaller operand
special_result  out  FP_W  final result when special_case = 1
special_case  out  1  mantissa datapath result must be ignored
out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (synchronous, active-high) clears both stage valids. Reset state: out_valid=0, in_ready=1; all data outputs 0. Reset mid-operation discards in-flight pairs; nothing is replayed.
- Latency: exactly 2 cycles from accept (in_valid&in_ready) to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Handshake:
  - Stage advances when its own slot is empty or the next slot advances.
  - in_ready = !s1_valid | s1_adv.
  - out_valid = s2_valid. Output data is held stable while out_valid & !out_ready.
  - in_ready is the only combinational path from out_ready.
- Stage 1:
  - Unpack the operands; effective sign_B = sign_B ^ op_sub.
  - Classify each operand as ZERO, DENORM, NORMAL, INF or NAN.
  - Hidden bit = 1 for NORMAL, 0 for DENORM/ZERO. Effective exponent for DENORM/ZERO = 1.
  - Magnitude compare on {exp, fraction}: the larger operand is "great"; on a tie A is great.
  - Compute shift = exp_great - exp_small (EXP_W bits, always >= 0).
  - Evaluate special cases.
- Stage 2: align.
  - Mantissa layout: [MW-1] = 0 (carry headroom), [MW-2] = hidden bit, next MAN_W = fraction, low GRS_W = 0.
  - mantis_small = mantissa >> shift. The LSB is ORed with the OR of all shifted-out bits (sticky).
  - If shift >= MW-1, mantis_small = {0..., sticky}, with sticky = (mantissa != 0).
- Special cases (special_case=1; priority top-down):
  - Any NAN → 0 / all-ones exp / MSB-of-fraction-set (canonical qNaN; 0x7FC00000 at defaults).
  - INF with INF and eff_sub → canonical qNaN.
  - Any INF → INF with that operand's effective sign.
  - Both ZERO → +0 unless both effective signs are 1, then -0.
  - Otherwise special_case=0 and special_result=0.
- The alignment fields are still driven (don't-care) when special_case=1.
- Simultaneous: an accept and an output handshake in the same cycle with both stages full must move without a bubble.

Decomposition:
- Shared package fp_pkg:
  - default EXP_W/MAN_W/GRS_W;
  - operand type enum (3-bit: ZERO=0, DENORM=1, NORMAL=2, INF=3, NAN=4);
  - canonical qNaN and INF constant functions of EXP_W/MAN_W.
- One sub-module: fp_align_shift, a combinational barrel right-shift with sticky collapse (params MW, EXP_W), instantiated in stage 2.

Test Plan:
- 0x3F800000 + 0x3F800000, op_sub=0 → out after 2 cycles:
  - exp=0x7F, mantis_great=mantis_small=0x4000000, eff_sub=0, special_case=0.
- 0x3F000000 + 0x3F800000 → great=B, exp=0x7F, mantis_great=0x4000000, mantis_small=0x2000000, sign_great=0.
- 0x3F800000 + 0x30800000 (shift 30) → mantis_small=0x0000001 (sticky only). Same operands with op_sub=1 → eff_sub=1.
- Special cases:
  - 0x7F800000 - 0x7F800000 → special_case=1, special_result=0x7FC00000.
  - 0x80000000 + 0x80000000 → 0x80000000.
  - 0x7FA00000 + anything → 0x7FC00000.
- Backpressure: 5 back-to-back pairs, out_ready low for 3 cycles → in_ready drops after 2 accepts. Results emerge in order with correct tags 0..4, and output data stays stable while stalled.
- Reset asserted while both stages are valid → next cycle out_valid=0 and in_ready=1. No stale result appears after reset is released.
